// File: rtl/rbm_neuron_core_if.sv
// Operand/result bus of the serial RBM neuron core.
// The sequencer (master) streams one operand per clock and collects the
// sampled hidden unit and the classifier spike from the core (slave).
interface rbm_neuron_core_if;
    localparam int unsigned W_WIDTH   = 12;
    localparam int unsigned PID_WIDTH = 10;
    localparam int unsigned HID_WIDTH = 9;

    logic [W_WIDTH-1:0]   Hvalue;
    logic [PID_WIDTH-1:0] pixel_id;
    logic                 pixel;
    logic                 HiddenSwitch;
    logic                 enable_hidden;
    logic                 enable_classi;
    logic [W_WIDTH-1:0]   Cvalue;
    logic [HID_WIDTH-1:0] hidden_id;
    logic                 hidden_pixel;
    logic                 hidden;
    logic                 hidden_finish;
    logic                 spike;
    logic                 finish;

    modport master (
        output Hvalue, pixel_id, pixel, HiddenSwitch, enable_hidden,
               enable_classi, Cvalue, hidden_id, hidden_pixel,
        input  hidden, hidden_finish, spike, finish
    );

    modport slave (
        input  Hvalue, pixel_id, pixel, HiddenSwitch, enable_hidden,
               enable_classi, Cvalue, hidden_id, hidden_pixel,
        output hidden, hidden_finish, spike, finish
    );
endinterface

// File: rtl/rbm_neuron_core.sv
// Serial neuron engine of the RBM classifier.
// Hidden phase accumulates gated weights over visible pixels, adds the bias at
// pixel_id==N_VISIBLE and samples one hidden unit; the classifier phase does the
// same over hidden bits and produces one output spike.
// Build option: define STOCH_CLASSI_EN for a stochastic classifier decision
// (s > rnd); otherwise the classifier fires deterministically on s >= 0.
module rbm_neuron_core (
    input  logic               clock,
    input  logic               reset,
    rbm_neuron_core_if.slave   bus
);
    localparam int unsigned FRAC_BITS  = 8;
    localparam int unsigned ACC_WIDTH  = 22;
    localparam int unsigned N_VISIBLE  = 784;
    localparam int unsigned N_HIDDEN   = 441;
    localparam int unsigned LFSR_WIDTH = 16;
    localparam int unsigned PID_WIDTH  = 10;
    localparam int unsigned HID_WIDTH  = 9;
    // Random threshold spans [-4.0, +4.0): FRAC_BITS fraction + 2 integer + sign.
    localparam int unsigned RND_WIDTH  = FRAC_BITS + 3;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;
    // Galois mask for x^16+x^14+x^13+x^11+1 in right-shift form.
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

    logic signed [ACC_WIDTH-1:0]  hacc_q, hacc_d;
    logic signed [ACC_WIDTH-1:0]  cacc_q, cacc_d;
    logic [LFSR_WIDTH-1:0]        lfsr_q, lfsr_d;
    logic                         hidden_q, hidden_d;
    logic                         hidden_finish_q, hidden_finish_d;
    logic                         spike_q, spike_d;
    logic                         finish_q, finish_d;

    logic signed [ACC_WIDTH-1:0]  h_term, c_term, h_sum, c_sum, rnd;
    logic                         h_fire, c_fire;

    // Gated, sign-extended terms, running sums and the sampling decisions.
    always_comb begin
        h_term = bus.pixel        ? ACC_WIDTH'($signed(bus.Hvalue)) : '0;
        c_term = bus.hidden_pixel ? ACC_WIDTH'($signed(bus.Cvalue)) : '0;
        h_sum  = hacc_q + h_term;
        c_sum  = cacc_q + c_term;
        rnd    = ACC_WIDTH'($signed(lfsr_q[RND_WIDTH-1:0]));
        h_fire = bus.HiddenSwitch ? (h_sum > rnd) : ~h_sum[ACC_WIDTH-1];
`ifdef STOCH_CLASSI_EN
        c_fire = (c_sum > rnd);
`else
        c_fire = ~c_sum[ACC_WIDTH-1];
`endif
    end

    // Next-state: accumulate in the active phase, sample on the bias operand.
    always_comb begin
        hacc_d          = hacc_q;
        cacc_d          = cacc_q;
        hidden_d        = hidden_q;
        spike_d         = spike_q;
        hidden_finish_d = 1'b0;
        finish_d        = 1'b0;
        lfsr_d          = {1'b0, lfsr_q[LFSR_WIDTH-1:1]}
                          ^ (lfsr_q[0] ? LFSR_TAPS : '0);

        if (bus.enable_hidden && !bus.enable_classi) begin
            if (bus.pixel_id == '0) begin
                hacc_d = h_term;
            end else if (bus.pixel_id < PID_WIDTH'(N_VISIBLE)) begin
                hacc_d = h_sum;
            end else if (bus.pixel_id == PID_WIDTH'(N_VISIBLE)) begin
                hacc_d          = h_sum;
                hidden_d        = h_fire;
                hidden_finish_d = 1'b1;
            end
        end else if (bus.enable_classi && !bus.enable_hidden) begin
            if (bus.hidden_id == '0) begin
                cacc_d = c_term;
            end else if (bus.hidden_id < HID_WIDTH'(N_HIDDEN)) begin
                cacc_d = c_sum;
            end else if (bus.hidden_id == HID_WIDTH'(N_HIDDEN)) begin
                cacc_d   = c_sum;
                spike_d  = c_fire;
                finish_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            hacc_q          <= '0;
            cacc_q          <= '0;
            lfsr_q          <= LFSR_SEED;
            hidden_q        <= 1'b0;
            hidden_finish_q <= 1'b0;
            spike_q         <= 1'b0;
            finish_q        <= 1'b0;
        end else begin
            hacc_q          <= hacc_d;
            cacc_q          <= cacc_d;
            lfsr_q          <= lfsr_d;
            hidden_q        <= hidden_d;
            hidden_finish_q <= hidden_finish_d;
            spike_q         <= spike_d;
            finish_q        <= finish_d;
        end
    end

    assign bus.hidden        = hidden_q;
    assign bus.hidden_finish = hidden_finish_q;
    assign bus.spike         = spike_q;
    assign bus.finish        = finish_q;
endmodule

// File: tb/tb_rbm_neuron_core.sv
// Directed bench for rbm_neuron_core: expected samples are queued when a bias
// operand is driven and compared when the matching completion pulse appears.
module tb_rbm_neuron_core;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    rbm_neuron_core_if bus();

    rbm_neuron_core dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic val;
        bit   chk;
    } exp_t;

    exp_t hq[$];
    exp_t sq[$];
    exp_t he;
    exp_t se;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   rate_ones = 0;
    int   rate_runs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // Scoreboard: pop and compare on every completion pulse.
    always @(negedge clock) begin
        if (bus.hidden_finish === 1'b1) begin
            if (hq.size() == 0) begin
                check("hidden_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                he = hq.pop_front();
                if (he.chk) check("hidden_value", 32'(bus.hidden), 32'(he.val));
                else begin
                    rate_runs++;
                    if (bus.hidden === 1'b1) rate_ones++;
                end
            end
        end
        if (bus.finish === 1'b1) begin
            if (sq.size() == 0) begin
                check("spike_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                se = sq.pop_front();
                check("spike_value", 32'(bus.spike), 32'(se.val));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.enable_hidden = 1'b0;
        bus.enable_classi = 1'b0;
        tick();
    endtask

    task automatic h_op(input int id, input logic px, input logic [11:0] v);
        bus.enable_hidden = 1'b1;
        bus.enable_classi = 1'b0;
        bus.pixel_id      = 10'(id);
        bus.pixel         = px;
        bus.Hvalue        = v;
        tick();
    endtask

    task automatic c_op(input int id, input logic hp, input logic [11:0] v);
        bus.enable_hidden = 1'b0;
        bus.enable_classi = 1'b1;
        bus.hidden_id     = 9'(id);
        bus.hidden_pixel  = hp;
        bus.Cvalue        = v;
        tick();
    endtask

    // Bias edge, then pulse high for exactly the following cycle.
    task automatic h_bias(input logic [11:0] v, input logic exp_v);
        exp_t e;
        e.val = exp_v;
        e.chk = 1'b1;
        hq.push_back(e);
        h_op(784, 1'b1, v);
        check("hidden_finish_high", 32'(bus.hidden_finish), 32'd1);
        idle();
        check("hidden_finish_low", 32'(bus.hidden_finish), 32'd0);
    endtask

    task automatic c_bias(input logic [11:0] v, input logic exp_v);
        exp_t e;
        e.val = exp_v;
        e.chk = 1'b1;
        sq.push_back(e);
        c_op(441, 1'b1, v);
        check("finish_high", 32'(bus.finish), 32'd1);
        idle();
        check("finish_low", 32'(bus.finish), 32'd0);
    endtask

    task automatic h_run(input logic px, input logic [11:0] w, input logic [11:0] b, input logic exp_v);
        for (int i = 0; i < 784; i++) h_op(i, px, w);
        h_bias(b, exp_v);
    endtask

    task automatic c_run(input logic hp, input logic [11:0] w, input logic [11:0] b, input logic exp_v);
        for (int i = 0; i < 441; i++) c_op(i, hp, w);
        c_bias(b, exp_v);
    endtask

    initial begin
        exp_t e;
        reset             = 1'b1;
        bus.Hvalue        = '0;
        bus.pixel_id      = '0;
        bus.pixel         = 1'b0;
        bus.HiddenSwitch  = 1'b0;
        bus.enable_hidden = 1'b0;
        bus.enable_classi = 1'b0;
        bus.Cvalue        = '0;
        bus.hidden_id     = '0;
        bus.hidden_pixel  = 1'b0;

        repeat (3) tick();
        check("rst_hidden", 32'(bus.hidden), 32'd0);
        check("rst_spike", 32'(bus.spike), 32'd0);
        check("rst_hidden_finish", 32'(bus.hidden_finish), 32'd0);
        check("rst_finish", 32'(bus.finish), 32'd0);
        reset = 1'b0;
        idle();

        // Deterministic: 784 x 1 + (-1) = 783 -> fire.
        bus.HiddenSwitch = 1'b0;
        h_run(1'b1, 12'h001, 12'hFFF, 1'b1);

        // Pixels gate large weights off; only the bias decides.
        h_run(1'b0, 12'h7FF, 12'h800, 1'b0);
        h_op(0, 1'b0, 12'h7FF);
        h_bias(12'h000, 1'b1);

        // Stochastic with saturated sums.
        bus.HiddenSwitch = 1'b1;
        repeat (2) h_run(1'b1, 12'h7FF, 12'h7FF, 1'b1);
        repeat (2) h_run(1'b1, 12'h800, 12'h800, 1'b0);

        // Stochastic with s=0: firing rate near one half.
        for (int r = 0; r < 1000; r++) begin
            e.val = 1'b0;
            e.chk = 1'b0;
            hq.push_back(e);
            h_op(0, 1'b1, 12'h000);
            h_op(784, 1'b1, 12'h000);
        end
        idle();
        check("rate_runs", 32'(rate_runs), 32'd1000);
        check("rate_40_60", 32'((rate_ones >= 400) && (rate_ones <= 600)), 32'd1);

        // Illegal both-enables window in the middle of a run.
        bus.HiddenSwitch = 1'b0;
        h_op(0, 1'b1, 12'h7FF);
        h_bias(12'h000, 1'b1);
        for (int i = 0; i < 400; i++) h_op(i, 1'b1, 12'hFFF);
        for (int k = 0; k < 5; k++) begin
            bus.enable_hidden = 1'b1;
            bus.enable_classi = 1'b1;
            bus.pixel_id      = (k % 2 == 0) ? 10'd0 : 10'd784;
            bus.pixel         = 1'b1;
            bus.Hvalue        = 12'h7FF;
            bus.hidden_id     = 9'd441;
            bus.hidden_pixel  = 1'b1;
            bus.Cvalue        = 12'h7FF;
            tick();
            check("both_en_no_hpulse", 32'(bus.hidden_finish), 32'd0);
            check("both_en_no_cpulse", 32'(bus.finish), 32'd0);
            check("both_en_hidden_hold", 32'(bus.hidden), 32'd1);
        end
        h_op(900, 1'b1, 12'h7FF);
        for (int i = 400; i < 784; i++) h_op(i, 1'b1, 12'hFFF);
        h_bias(12'h000, 1'b0);

        // Classifier: 441 x 16 - 256 = 6800 -> spike; negative sum -> no spike.
        c_run(1'b1, 12'h010, 12'hF00, 1'b1);
        c_run(1'b1, 12'hFF0, 12'h000, 1'b0);
        check("classi_keeps_hidden", 32'(bus.hidden), 32'd0);

        // Reset mid-phase clears spike and the accumulator, without a pulse.
        c_op(0, 1'b1, 12'h7FF);
        c_bias(12'h000, 1'b1);
        for (int i = 0; i < 10; i++) c_op(i, 1'b1, 12'h010);
        reset         = 1'b1;
        bus.hidden_id = 9'd441;
        tick();
        check("midrst_spike", 32'(bus.spike), 32'd0);
        check("midrst_finish", 32'(bus.finish), 32'd0);
        reset = 1'b0;
        idle();
        check("midrst_no_pulse", 32'(bus.finish), 32'd0);
        c_bias(12'hFFF, 1'b0);

        idle();
        check("hidden_queue_drained", 32'(hq.size()), 32'd0);
        check("spike_queue_drained", 32'(sq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
